// File: rtl/dly_bank_pkg.sv
// dly_bank_pkg: shared constants, width helpers and the config record for dly_bank.
package dly_bank_pkg;

    localparam int DEF_CHANNELS = 10;
    localparam int DEF_DEPTH    = 8;

    // tap_sel width: enough for DEPTH-1 plus one spare bit to spot out-of-range requests
    function automatic int sel_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic [sel_w(DEF_DEPTH)-1:0] tap;
        logic [DEF_CHANNELS-1:0]     mask;
    } cfg_t;

endpackage

// File: rtl/dly_chan_pipe.sv
// dly_chan_pipe: one-bit DEPTH-stage shift register with a selectable read tap.
module dly_chan_pipe import dly_bank_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    localparam int IDX_W = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             d,
    input  logic [IDX_W-1:0] tap,
    output logic             q
);

    logic [DEPTH-1:0] stage;

    // clr wipes every stage behind the one being loaded this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stage <= '0;
        else
            stage <= clr ? {{(DEPTH-1){1'b0}}, d} : {stage[DEPTH-2:0], d};
    end

    assign q = stage[tap];

endmodule

// File: rtl/dly_bank.sv
// dly_bank: multi-channel programmable-delay bank with per-channel inversion.
// Define DLY_BANK_CHECK_EN to add the expected-data comparator (exp_*, mismatch, err_cnt).
module dly_bank import dly_bank_pkg::*; #(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH,
    localparam int SEL_W   = sel_w(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [CHANNELS-1:0] in_data,
    input  logic                flush,
    input  logic                cfg_load,
    input  logic [SEL_W-1:0]    tap_sel,
    input  logic [CHANNELS-1:0] inv_mask,
    output logic                out_valid,
    output logic [CHANNELS-1:0] out_data,
    output logic                busy,
    output logic                cfg_err,
    output logic [SEL_W-1:0]    in_flight
`ifdef DLY_BANK_CHECK_EN
    ,
    input  logic [CHANNELS-1:0] exp_data,
    input  logic                exp_valid,
    output logic                mismatch,
    output logic [15:0]         err_cnt
`endif
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam logic [IDX_W-1:0] TAP_MAX = IDX_W'(DEPTH - 1);
    localparam logic [SEL_W-1:0] CNT_MAX = SEL_W'(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0]    tap;
        logic [CHANNELS-1:0] mask;
    } act_cfg_t;

    act_cfg_t            cfg_q;
    logic [SEL_W-1:0]    count;
    logic [SEL_W-1:0]    cnt_nxt;
    logic                in_take;
    logic                cfg_take;
    logic                cfg_bad;
    logic                tap_v;
    logic [CHANNELS-1:0] tap_d;

    assign in_take   = in_valid & ~flush;
    assign cfg_take  = cfg_load & ~flush & ~busy;
    assign cfg_bad   = tap_sel >= CNT_MAX;
    assign busy      = count != '0;
    assign in_flight = count;

    // Accepting a config also clears stale valid bits left beyond the old tap,
    // so a longer new tap cannot re-emit patterns that already left.
    dly_chan_pipe #(.DEPTH(DEPTH)) u_vpipe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush | cfg_take),
        .d     (in_take),
        .tap   (cfg_q.tap),
        .q     (tap_v)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        dly_chan_pipe #(.DEPTH(DEPTH)) u_pipe (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (1'b0),
            .d     (in_data[c]),
            .tap   (cfg_q.tap),
            .q     (tap_d[c])
        );
    end

    // A pattern stops counting at the edge it is latched into the output register.
    always_comb
        cnt_nxt = (in_take && !tap_v && count != CNT_MAX) ? count + SEL_W'(1) :
                  (!in_take && tap_v && count != '0)      ? count - SEL_W'(1) : count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q     <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cfg_err   <= 1'b0;
        end else begin
            out_valid <= tap_v & ~flush;
            if (tap_v && !flush)
                out_data <= tap_d ^ cfg_q.mask;
            cfg_err <= cfg_load & ~flush & (busy | cfg_bad);
            if (cfg_take)
                cfg_q <= '{tap: cfg_bad ? TAP_MAX : tap_sel[IDX_W-1:0], mask: inv_mask};
            count <= flush ? '0 : cnt_nxt;
        end
    end

`ifdef DLY_BANK_CHECK_EN
    logic miss;

    assign miss = out_valid & exp_valid & (exp_data != out_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            mismatch <= miss;
            if (miss && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dly_bank.sv
// tb_dly_bank: directed self-checking bench for dly_bank (CHANNELS=10, DEPTH=8).
module tb_dly_bank;
    import dly_bank_pkg::*;

    localparam int CH = 10;
    localparam int DP = 8;
    localparam int SW = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush    = 1'b0;
    logic          cfg_load = 1'b0;
    logic [CH-1:0] in_data  = '0;
    logic [CH-1:0] inv_mask = '0;
    logic [SW-1:0] tap_sel  = '0;
    logic [CH-1:0] out_data;
    logic [SW-1:0] in_flight;
    logic          out_valid;
    logic          busy;
    logic          cfg_err;
    logic          seen;
    int            n_tests = 0;
    int            n_fail  = 0;
`ifdef DLY_BANK_CHECK_EN
    logic [CH-1:0] exp_data  = '0;
    logic          exp_valid = 1'b0;
    logic          mismatch;
    logic [15:0]   err_cnt;
`endif

    always #5 clk = ~clk;

    dly_bank #(.CHANNELS(CH), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .cfg_load  (cfg_load),
        .tap_sel   (tap_sel),
        .inv_mask  (inv_mask),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .in_flight (in_flight)
`ifdef DLY_BANK_CHECK_EN
        ,
        .exp_data  (exp_data),
        .exp_valid (exp_valid),
        .mismatch  (mismatch),
        .err_cnt   (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input cfg_t c);
        cfg_load = 1'b1;
        tap_sel  = c.tap;
        inv_mask = c.mask;
        step();
        cfg_load = 1'b0;
        inv_mask = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, cfg_err, 0);
        check({tag, "_flight"}, in_flight, 0);
    endtask

    initial begin
        step();
        step();
        check_idle("rst");
        rst_n = 1'b1;
        step();

        // tap 2, no inversion: single pattern comes out 3 edges later
        load('{tap: 4'd2, mask: 10'h000});
        check("a_cfg_err", cfg_err, 0);
        in_valid = 1'b1;
        in_data  = 10'h2A5;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        check("a_flight", in_flight, 1);
        check("a_busy1", busy, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("a_valid_e%0d", k), out_valid, k == 3);
            if (k == 3) check("a_data", out_data, 10'h2A5);
        end
        check("a_busy0", busy, 0);

        // tap 0, full inversion, back-to-back patterns
        load('{tap: 4'd0, mask: 10'h3FF});
        in_valid = 1'b1;
        in_data  = 10'h0F0;
        step();
        check("b_valid_e0", out_valid, 0);
        in_data = 10'h001;
        step();
        check("b_valid_e1", out_valid, 1);
        check("b_data_e1", out_data, 10'h30F);
        in_valid = 1'b0;
        in_data  = '0;
        step();
        check("b_valid_e2", out_valid, 1);
        check("b_data_e2", out_data, 10'h3FE);
        step();
        check("b_valid_e3", out_valid, 0);
        check("b_hold_e3", out_data, 10'h3FE);

        // tap 3; a config request while busy is rejected and changes nothing
        load('{tap: 4'd3, mask: 10'h000});
        for (int k = 0; k <= 8; k++) begin
            in_valid = k < 4;
            in_data  = CH'(1 << k);
            cfg_load = k == 2;
            tap_sel  = '0;
            inv_mask = '1;
            step();
            check($sformatf("c_valid_e%0d", k), out_valid, k >= 4 && k <= 7);
            if (k >= 4 && k <= 7) check($sformatf("c_data_e%0d", k), out_data, 32'(1 << (k - 4)));
            check($sformatf("c_err_e%0d", k), cfg_err, k == 2);
            if (k == 3) check("c_flight", in_flight, 4);
        end
        in_valid = 1'b0;
        cfg_load = 1'b0;
        inv_mask = '0;
        in_data  = '0;

        // out-of-range tap clamps to DEPTH-1 with a cfg_err pulse
        load('{tap: 4'd9, mask: 10'h000});
        check("d_cfg_err", cfg_err, 1);
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_data  = CH'(k + 1);
            step();
            if (k == 0) check("d_err_pulse", cfg_err, 0);
            check($sformatf("d_valid_e%0d", k), out_valid, k >= 8);
            if (k >= 8) check($sformatf("d_data_e%0d", k), out_data, k - 7);
            if (k == 7 || k == 11) check($sformatf("d_flight_e%0d", k), in_flight, 8);
        end
        in_valid = 1'b0;
        in_data  = '0;
        for (int k = 12; k < 22; k++) step();
        check("d_drain_valid", out_valid, 0);
        check("d_drain_busy", busy, 0);

        // config and pattern in the same idle cycle: pattern uses the new tap and mask
        cfg_load = 1'b1;
        tap_sel  = 4'd1;
        inv_mask = 10'h00F;
        in_valid = 1'b1;
        in_data  = 10'h0F0;
        step();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        inv_mask = '0;
        check("f_cfg_err", cfg_err, 0);
        step();
        check("f_valid_e1", out_valid, 0);
        step();
        check("f_valid_e2", out_valid, 1);
        check("f_data_e2", out_data, 10'h0FF);
        step();
        check("f_valid_e3", out_valid, 0);

        // flush with 4 in flight, colliding with a new input and a config request
        load('{tap: 4'd3, mask: 10'h000});
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 10'h3FF;
            step();
        end
        check("e_flight", in_flight, 4);
        flush    = 1'b1;
        cfg_load = 1'b1;
        tap_sel  = 4'd0;
        inv_mask = '1;
        step();
        flush    = 1'b0;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        inv_mask = '0;
        in_data  = '0;
        check("e_valid", out_valid, 0);
        check("e_busy", busy, 0);
        check("e_flight0", in_flight, 0);
        check("e_cfg_err", cfg_err, 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            seen |= out_valid;
        end
        check("e_no_emit", seen, 0);
        in_valid = 1'b1;
        in_data  = 10'h155;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        for (int k = 1; k <= 4; k++) step();
        check("e_kept_valid", out_valid, 1);
        check("e_kept_data", out_data, 10'h155);
        step();

        // asynchronous reset with 3 patterns in flight
        load('{tap: 4'd7, mask: 10'h000});
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 10'h3C3;
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
        step();
        check("g_flight", in_flight, 3);
        #2 rst_n = 1'b0;
        #1 check_idle("g_rst");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            seen |= out_valid;
        end
        check("g_no_emit", seen, 0);
        in_valid = 1'b1;
        in_data  = 10'h2AA;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        check("g_tap0_e0", out_valid, 0);
        step();
        check("g_tap0_valid", out_valid, 1);
        check("g_tap0_data", out_data, 10'h2AA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
